// File: rtl/program_loader.sv
// program_loader: receives a byte-stream program image (16-bit word count header,
// then N words MSB first), writes the words sequentially into program memory and
// holds the processor in reset until the image is complete.
// Optional feature macro: CHECKSUM_EN adds a trailing XOR checksum byte (CHK state).
// Handshake: a byte is taken on any rising CLK edge where RX_VALID && RX_READY;
// RX_READY depends only on the current state, so it never combinationally follows RX_VALID.
module program_loader #(
    parameter int ADDR_W         = 12,
    parameter int BASE_ADDR      = 0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              START,
    input  logic [7:0]        RX_DATA,
    input  logic              RX_VALID,
    output logic              RX_READY,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [15:0]       MEM_WDATA,
    output logic              CPU_RESET,
    output logic              DONE,
    output logic              ERROR,
    output logic [ADDR_W:0]   WORD_COUNT,
    output logic [3:0]        DBG_STATE
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_HDR_HI  = 4'd1,
        S_HDR_LO  = 4'd2,
        S_DATA_HI = 4'd3,
        S_DATA_LO = 4'd4,
        S_WRITE   = 4'd5,
`ifdef CHECKSUM_EN
        S_CHK     = 4'd6,
`endif
        S_DONE    = 4'd7,
        S_ERR     = 4'd8
    } state_t;

    // Largest word count that fits between BASE_ADDR and the top of memory.
    localparam logic [31:0] MAX_WORDS = 32'((1 << ADDR_W) - BASE_ADDR);
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t              state, state_next;
    logic                accept;
    logic                can_start;
    logic                last_word;
    logic [15:0]         hdr_n;
    logic [7:0]          hdr_hi_q;
    logic [7:0]          data_hi_q;
    logic [15:0]         n_words;
    logic [ADDR_W:0]     word_count;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [15:0]         mem_wdata_q;
    logic [TMO_W-1:0]    tmo_cnt;
`ifdef CHECKSUM_EN
    logic [7:0]          chk_acc;
`endif

    assign RX_READY = (state == S_HDR_HI) || (state == S_HDR_LO) ||
                      (state == S_DATA_HI) || (state == S_DATA_LO)
`ifdef CHECKSUM_EN
                      || (state == S_CHK)
`endif
                      ;
    assign accept    = RX_VALID && RX_READY;
    assign can_start = START && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
    assign hdr_n     = {hdr_hi_q, RX_DATA};
    assign last_word = (32'(word_count) + 32'd1) == 32'(n_words);

    assign MEM_WE     = (state == S_WRITE);
    assign MEM_ADDR   = mem_addr_q;
    assign MEM_WDATA  = mem_wdata_q;
    assign CPU_RESET  = (state != S_DONE);
    assign DONE       = (state == S_DONE);
    assign ERROR      = (state == S_ERR);
    assign WORD_COUNT = word_count;
    assign DBG_STATE  = state;

    // State register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= S_IDLE;
        else          state <= state_next;
    end

    // Next-state logic, including the header range check and the byte timeout.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: if (can_start) state_next = S_HDR_HI;
            S_HDR_HI:  if (accept) state_next = S_HDR_LO;
            S_HDR_LO:  if (accept) begin
                if (hdr_n == 16'd0 || 32'(hdr_n) > MAX_WORDS) state_next = S_ERR;
                else                                           state_next = S_DATA_HI;
            end
            S_DATA_HI: if (accept) state_next = S_DATA_LO;
            S_DATA_LO: if (accept) state_next = S_WRITE;
`ifdef CHECKSUM_EN
            S_WRITE:   state_next = last_word ? S_CHK : S_DATA_HI;
            S_CHK:     if (accept) state_next = (RX_DATA == chk_acc) ? S_DONE : S_ERR;
`else
            S_WRITE:   state_next = last_word ? S_DONE : S_DATA_HI;
`endif
            default:   state_next = S_IDLE;
        endcase
        if (TIMEOUT_CYCLES != 0 && RX_READY && !accept && tmo_cnt == TMO_LAST)
            state_next = S_ERR;
    end

    // Idle-cycle counter: restarts on every accepted byte and every state change.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)                                       tmo_cnt <= '0;
        else if (!RX_READY || accept || state_next != state) tmo_cnt <= '0;
        else                                                tmo_cnt <= tmo_cnt + 1'b1;
    end

    // Datapath: header capture, byte packing, write address/data and word counter.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hdr_hi_q    <= '0;
            data_hi_q   <= '0;
            n_words     <= '0;
            word_count  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef CHECKSUM_EN
            chk_acc     <= '0;
`endif
        end else begin
            if (can_start) begin
                word_count <= '0;
`ifdef CHECKSUM_EN
                chk_acc    <= '0;
`endif
            end
            if (accept) begin
                case (state)
                    S_HDR_HI:  hdr_hi_q <= RX_DATA;
                    S_HDR_LO:  n_words  <= hdr_n;
                    S_DATA_HI: begin
                        data_hi_q <= RX_DATA;
`ifdef CHECKSUM_EN
                        chk_acc   <= chk_acc ^ RX_DATA;
`endif
                    end
                    S_DATA_LO: begin
                        // Address/data are loaded here so they are stable for the whole
                        // WRITE cycle and keep their value afterwards.
                        mem_addr_q  <= ADDR_W'(BASE_ADDR + int'(word_count));
                        mem_wdata_q <= {data_hi_q, RX_DATA};
`ifdef CHECKSUM_EN
                        chk_acc     <= chk_acc ^ RX_DATA;
`endif
                    end
                    default: ;
                endcase
            end
            if (state == S_WRITE) word_count <= word_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed testbench for program_loader: a vector table of whole frames plus
// hand-written sequences for latency, timeout, mid-load reset and START handling.
module tb_program_loader;

  localparam int ADDR_W = 12;
  localparam int W      = ADDR_W + 16;

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_HDR_HI  = 4'd1;
  localparam logic [3:0] ST_DATA_LO = 4'd4;
  localparam logic [3:0] ST_WRITE   = 4'd5;
  localparam logic [3:0] ST_DONE    = 4'd7;
  localparam logic [3:0] ST_ERR     = 4'd8;

  logic              CLK = 1'b0;
  logic              RESET_N;
  logic              START;
  logic [7:0]        RX_DATA;
  logic              RX_VALID;
  logic              RX_READY;
  logic              MEM_WE;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [15:0]       MEM_WDATA;
  logic              CPU_RESET;
  logic              DONE;
  logic              ERROR;
  logic [ADDR_W:0]   WORD_COUNT;
  logic [3:0]        DBG_STATE;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [W-1:0] exp_q[$];

  typedef struct packed {
    logic [15:0] n;
    logic [47:0] words;      // word 0 in [47:32]
    logic [1:0]  nsend;
    logic        exp_done;
    logic        exp_err;
    logic [12:0] exp_count;
  } vec_t;

  vec_t vecs[5];

  program_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(0), .TIMEOUT_CYCLES(1024)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .RX_READY(RX_READY), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .CPU_RESET(CPU_RESET), .DONE(DONE), .ERROR(ERROR), .WORD_COUNT(WORD_COUNT),
    .DBG_STATE(DBG_STATE)
  );

  // Clock and watchdog.
  always #5 CLK = ~CLK;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 900000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: got no handshake expected RX_READY within bound", name);
  endtask

  // Scoreboard: every write strobe must match the head of exp_q.
  always @(negedge CLK) begin : mem_monitor
    logic [W-1:0] got;
    if (MEM_WE === 1'b1) begin
      got = {MEM_ADDR, MEM_WDATA};
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_write: got %0h expected no write", got);
      end else begin
        check("mem_write", 32'(got), 32'(exp_q.pop_front()));
      end
    end
  end

  // Driver tasks: all start and end 1 ns after a rising edge.
  task automatic pulse_start();
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    RX_DATA  = b;
    RX_VALID = 1'b1;
    @(negedge CLK);
    while (RX_READY !== 1'b1 && n < 1100) begin
      @(negedge CLK);
      n++;
    end
    if (RX_READY !== 1'b1) note_fail("send_byte_ready");
    @(posedge CLK); #1;
    RX_VALID = 1'b0;
  endtask

  task automatic send_word(input logic [11:0] addr, input logic [15:0] w);
    exp_q.push_back({addr, w});
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic finish_frame(input logic [7:0] chk);
`ifdef CHECKSUM_EN
    send_byte(chk);
`else
    if (chk === 8'hxx) $display("checksum byte not used");
    @(posedge CLK); #1;
`endif
  endtask

  initial begin
    vec_t         v;
    logic [47:0]  wv;
    logic [15:0]  w;
    logic [7:0]   chk;
    logic [11:0]  last_addr;
    logic [15:0]  last_data;

    vecs[0] = '{n: 16'h0003, words: {16'h3000, 16'hA005, 16'h2014}, nsend: 2'd3,
                exp_done: 1'b1, exp_err: 1'b0, exp_count: 13'd3};
    vecs[1] = '{n: 16'h0000, words: 48'h0, nsend: 2'd0,
                exp_done: 1'b0, exp_err: 1'b1, exp_count: 13'd0};
    vecs[2] = '{n: 16'h1001, words: 48'h0, nsend: 2'd0,
                exp_done: 1'b0, exp_err: 1'b1, exp_count: 13'd0};
    vecs[3] = '{n: 16'h0001, words: {16'hFFFF, 32'h0}, nsend: 2'd1,
                exp_done: 1'b1, exp_err: 1'b0, exp_count: 13'd1};
    vecs[4] = '{n: 16'h0002, words: {16'h0001, 16'h8000, 16'h0}, nsend: 2'd2,
                exp_done: 1'b1, exp_err: 1'b0, exp_count: 13'd2};
    last_addr = '0;
    last_data = '0;

    // Reset block.
    RESET_N  = 1'b0;
    START    = 1'b0;
    RX_DATA  = 8'h00;
    RX_VALID = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_rx_ready", 32'(RX_READY), 0);
    check("rst_mem_we", 32'(MEM_WE), 0);
    check("rst_mem_addr", 32'(MEM_ADDR), 0);
    check("rst_mem_wdata", 32'(MEM_WDATA), 0);
    check("rst_cpu_reset", 32'(CPU_RESET), 1);
    check("rst_done", 32'(DONE), 0);
    check("rst_error", 32'(ERROR), 0);
    check("rst_word_count", 32'(WORD_COUNT), 0);
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK); #1;
    check("idle_state", 32'(DBG_STATE), 32'(ST_IDLE));

    // Vector table: whole frames.
    for (int i = 0; i < 5; i++) begin
      v  = vecs[i];
      wv = v.words;
      chk = 8'h00;
      pulse_start();
      send_byte(v.n[15:8]);
      send_byte(v.n[7:0]);
      for (int j = 0; j < int'(v.nsend); j++) begin
        w = wv[47 - 16*j -: 16];
        send_word(12'(j), w);
        chk = chk ^ w[15:8] ^ w[7:0];
        last_addr = 12'(j);
        last_data = w;
      end
      if (v.exp_done) finish_frame(chk);
      check($sformatf("vec%0d_done", i), 32'(DONE), 32'(v.exp_done));
      check($sformatf("vec%0d_error", i), 32'(ERROR), 32'(v.exp_err));
      check($sformatf("vec%0d_cpu_reset", i), 32'(CPU_RESET), 32'(!v.exp_done));
      check($sformatf("vec%0d_word_count", i), 32'(WORD_COUNT), 32'(v.exp_count));
      check($sformatf("vec%0d_state", i), 32'(DBG_STATE), v.exp_done ? 32'(ST_DONE) : 32'(ST_ERR));
      check($sformatf("vec%0d_addr_hold", i), 32'(MEM_ADDR), 32'(last_addr));
      check($sformatf("vec%0d_data_hold", i), 32'(MEM_WDATA), 32'(last_data));
      check($sformatf("vec%0d_rx_ready", i), 32'(RX_READY), 0);
    end

    // START while in DATA_LO is ignored; write latency after the low byte.
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h02);
    exp_q.push_back({12'd0, 16'h1234});
    send_byte(8'h12);
    check("mid_state_data_lo", 32'(DBG_STATE), 32'(ST_DATA_LO));
    pulse_start();
    check("start_ignored_state", 32'(DBG_STATE), 32'(ST_DATA_LO));
    check("start_ignored_ready", 32'(RX_READY), 1);
    send_byte(8'h34);
    check("lat_mem_we", 32'(MEM_WE), 1);
    check("lat_rx_ready", 32'(RX_READY), 0);
    check("lat_state", 32'(DBG_STATE), 32'(ST_WRITE));
    check("lat_addr", 32'(MEM_ADDR), 0);
    check("lat_wdata", 32'(MEM_WDATA), 32'h1234);
    check("lat_count_before", 32'(WORD_COUNT), 0);
    @(posedge CLK); #1;
    check("lat_count_after", 32'(WORD_COUNT), 1);
    check("lat_we_low", 32'(MEM_WE), 0);
    check("lat_ready_again", 32'(RX_READY), 1);
    send_word(12'd1, 16'h5678);
    finish_frame(8'h12 ^ 8'h34 ^ 8'h56 ^ 8'h78);
    check("s6_done", 32'(DONE), 1);
    check("s6_count", 32'(WORD_COUNT), 2);
    pulse_start();
    check("restart_cpu_reset", 32'(CPU_RESET), 1);
    check("restart_done", 32'(DONE), 0);
    check("restart_count", 32'(WORD_COUNT), 0);
    check("restart_state", 32'(DBG_STATE), 32'(ST_HDR_HI));

    // Timeout boundary: 1023 idle cycles still completes.
    send_byte(8'h00);
    send_byte(8'h01);
    exp_q.push_back({12'd0, 16'h9ABC});
    send_byte(8'h9A);
    repeat (1023) @(posedge CLK);
    #1;
    check("tmo1023_state", 32'(DBG_STATE), 32'(ST_DATA_LO));
    send_byte(8'hBC);
    finish_frame(8'h9A ^ 8'hBC);
    check("tmo1023_done", 32'(DONE), 1);

    // Timeout: 1024 idle cycles aborts on the 1024th.
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h11);
    repeat (1023) @(posedge CLK);
    #1;
    check("tmo_not_yet", 32'(ERROR), 0);
    @(posedge CLK); #1;
    check("tmo_error", 32'(ERROR), 1);
    check("tmo_state", 32'(DBG_STATE), 32'(ST_ERR));
    check("tmo_rx_ready", 32'(RX_READY), 0);
    check("tmo_cpu_reset", 32'(CPU_RESET), 1);
    check("tmo_data_hold", 32'(MEM_WDATA), 32'h9ABC);

    // Reset after the second word is written.
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h03);
    send_word(12'd0, 16'hAAAA);
    send_word(12'd1, 16'hBBBB);
    @(posedge CLK); #1;
    check("pre_rst_count", 32'(WORD_COUNT), 2);
    RESET_N = 1'b0;
    #1;
    check("mid_rst_addr", 32'(MEM_ADDR), 0);
    check("mid_rst_wdata", 32'(MEM_WDATA), 0);
    check("mid_rst_count", 32'(WORD_COUNT), 0);
    check("mid_rst_cpu_reset", 32'(CPU_RESET), 1);
    check("mid_rst_ready", 32'(RX_READY), 0);
    check("mid_rst_state", 32'(DBG_STATE), 32'(ST_IDLE));
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK); #1;
    // START together with RX_VALID in IDLE: that byte is not taken.
    RX_VALID = 1'b1;
    RX_DATA  = 8'hFF;
    pulse_start();
    RX_VALID = 1'b0;
    check("start_valid_state", 32'(DBG_STATE), 32'(ST_HDR_HI));
    send_byte(8'h00);
    send_byte(8'h01);
    send_word(12'd0, 16'hBEEF);
    finish_frame(8'hBE ^ 8'hEF);
    check("post_rst_done", 32'(DONE), 1);
    check("post_rst_count", 32'(WORD_COUNT), 1);
    check("post_rst_addr", 32'(MEM_ADDR), 0);

`ifdef CHECKSUM_EN
    // Checksum good and bad.
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h01);
    send_word(12'd0, 16'h12F0);
    send_byte(8'hE2);
    check("chk_good_done", 32'(DONE), 1);
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h01);
    send_word(12'd0, 16'h12F0);
    send_byte(8'h00);
    check("chk_bad_error", 32'(ERROR), 1);
    check("chk_bad_cpu_reset", 32'(CPU_RESET), 1);
    check("chk_bad_done", 32'(DONE), 0);
    check("chk_bad_count", 32'(WORD_COUNT), 1);
`endif

    // Final report.
    repeat (3) @(posedge CLK);
    #1;
    check("exp_q_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
